// File: rtl/xor_acc_pkg.sv
// Shared definitions for the XOR checksum accumulator: FSM state encoding and default widths.
// Optional frame word counter is enabled with XOR_ACC_COUNT_EN.
package xor_acc_pkg;

    localparam int N_DEFAULT  = 8;
    localparam int CW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } xor_acc_state_e;

endpackage

// File: rtl/xor_checksum_accumulator_if.sv
// Input beat stream and checksum result bundle for the XOR checksum accumulator.
// out_count exists only when XOR_ACC_COUNT_EN is defined.
interface xor_checksum_accumulator_if
    import xor_acc_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = CW_DEFAULT
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_csum;
`ifdef XOR_ACC_COUNT_EN
    logic [CW-1:0] out_count;
`endif

    modport master (
        output in_valid, in_data, in_first, in_last, out_ready,
`ifdef XOR_ACC_COUNT_EN
        input  out_count,
`endif
        input  in_ready, out_valid, out_csum
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, out_ready,
`ifdef XOR_ACC_COUNT_EN
        output out_count,
`endif
        output in_ready, out_valid, out_csum
    );

endinterface

// File: rtl/xor_acc_counter.sv
// Saturating frame word counter: load forces the count to 1, inc adds one until all-ones.
// Instantiated by the accumulator only when XOR_ACC_COUNT_EN is defined.
module xor_acc_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          inc,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] COUNT_MAX = '1;
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);

    // Load wins over increment so a frame restart always begins at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= COUNT_ONE;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + COUNT_ONE;
        end
    end

endmodule

// File: rtl/xor_checksum_accumulator.sv
// Folds the words of each framed beat stream into an N-bit XOR checksum and holds it until consumed.
// Define XOR_ACC_COUNT_EN to also count accepted words per frame on out_count.
module xor_checksum_accumulator
    import xor_acc_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    xor_checksum_accumulator_if.slave   bus
);

    xor_acc_state_e state;
    xor_acc_state_e state_next;

    logic [N-1:0] acc;
    logic         ready_q;
    logic         valid_q;
    logic         accept;
    logic         acc_load;
    logic         acc_fold;

    assign accept = bus.in_valid && ready_q;

    always_comb begin
        state_next = state;
        acc_load   = 1'b0;
        acc_fold   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && bus.in_first) begin
                    acc_load   = 1'b1;
                    state_next = bus.in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (bus.in_first) begin
                        acc_load = 1'b1;
                    end else begin
                        acc_fold = 1'b1;
                    end
                    if (bus.in_last) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track the FSM
    // exactly, yet in_ready still stays low for the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != HOLD);
            valid_q <= (state_next == HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_load) begin
            acc <= bus.in_data;
        end else if (acc_fold) begin
            acc <= acc ^ bus.in_data;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_csum  = acc;

`ifdef XOR_ACC_COUNT_EN
    logic [CW-1:0] word_count;

    xor_acc_counter #(
        .CW (CW)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (acc_load),
        .inc   (acc_fold),
        .count (word_count)
    );

    assign bus.out_count = word_count;
`endif

endmodule

// File: doc/xor_checksum_accumulator.md
XOR_CHECKSUM_ACCUMULATOR -- requirements
Module: xor_checksum_accumulator

Interface
REQ-001 Parameter N, default 8: width in bits of input word and checksum.
REQ-002 Parameter CW, default 16: width in bits of frame word counter.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1: input word present.
REQ-006 in_ready  output  1: block accepts input word this cycle.
REQ-007 in_data  input  N: word to fold into checksum (typically bit-wise XOR stage result).
REQ-008 in_first  input  1: accepted word is first of frame.
REQ-009 in_last  input  1: accepted word is last of frame.
REQ-010 out_valid  output  1: frame checksum available.
REQ-011 out_ready  input  1: downstream consumes checksum.
REQ-012 out_csum  output  N: XOR of all accepted words of the frame.
REQ-013 out_count  output  CW: number of accepted words in the frame (present only with XOR_ACC_COUNT_EN).

Function
REQ-014 Beat accepted when in_valid && in_ready, in the same cycle.
REQ-015 FSM states IDLE, ACCUM, HOLD; encoding in shared package.
REQ-016 IDLE: in_ready=1; accepted beat with in_first -> acc=in_data, count=1; go ACCUM, or HOLD if in_last also set.
REQ-017 IDLE: accepted beat without in_first is dropped; state stays IDLE; acc unchanged.
REQ-018 ACCUM: in_ready=1; accepted beat -> acc=acc^in_data, count=count+1; go HOLD if in_last.
REQ-019 ACCUM: accepted beat with in_first restarts frame: acc=in_data, count=1 (prior partial frame discarded).
REQ-020 HOLD: in_ready=0, out_valid=1, out_csum=acc, out_count=count; all held stable until out_ready.
REQ-021 HOLD with out_ready=1 -> IDLE next cycle; no input beat accepted in that cycle.
REQ-022 Latency: out_valid asserts the cycle after the in_last beat is accepted.
REQ-023 out_valid registered; never asserted outside HOLD.
REQ-024 Counter saturates at 2^CW-1; further beats still fold into acc.
REQ-025 in_first/in_last ignored when beat not accepted.

Reset
REQ-026 While rst_n=0: state=IDLE, acc=0, count=0, out_valid=0, in_ready=0.
REQ-027 in_ready rises the first cycle after rst_n deasserts; reset mid-frame or in HOLD discards frame, no checksum emitted.

Configuration
REQ-028 Macro XOR_ACC_COUNT_EN defined: counter and out_count port compiled in per REQ-013/016/018/024.
REQ-029 Macro XOR_ACC_COUNT_EN undefined: no counter, no out_count port; all other behaviour identical.

Structure
REQ-030 Package xor_acc_pkg holds state enum typedef and default N/CW constants.
REQ-031 Sub-module xor_acc_counter (saturating CW-bit counter, load-1/increment) instantiated only under XOR_ACC_COUNT_EN.

Verification
REQ-032 Frame 0x12,0x34,0x56 (first on beat1, last on beat3), out_ready=1 -> out_csum=0x70, out_count=3, out_valid one cycle after beat3.
REQ-033 Single beat 0xA5 with first&last -> out_csum=0xA5, out_count=1; out_valid held 5 cycles with out_ready=0, in_ready=0 throughout, values stable.
REQ-034 Frame 0xFF,0x0F then first on 0x01, last on 0x02 -> restart; out_csum=0x03, out_count=2.
REQ-035 Beat 0x55 without first in IDLE, then frame 0x01 (first&last) -> out_csum=0x01; 0x55 dropped.
REQ-036 rst_n pulsed low after 2 beats of frame -> out_valid stays 0, in_ready=0 during reset; next frame 0x3C (first&last) -> out_csum=0x3C.
REQ-037 CW=2, frame of 5 beats of 0x01 -> out_count=3 (saturated), out_csum=0x01.
